// File: rtl/pulse_mon_pkg.sv
// -----------------------------------------------------------------------------
// pulse_mon_pkg
// Shared types and constants for the pulse period monitor.
//   mon_state_e : monitor FSM states (IDLE, ARM, RUN)
//   ERR_W       : width of the saturating error counter
//   ERR_MAX     : saturation value of the error counter
//   err_inc     : saturating increment used by the error counter
// -----------------------------------------------------------------------------
package pulse_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } mon_state_e;

    localparam int             ERR_W   = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = 8'd255;

    function automatic logic [ERR_W-1:0] err_inc(input logic [ERR_W-1:0] cur);
        return (cur == ERR_MAX) ? cur : cur + ERR_W'(1);
    endfunction

endpackage

// File: rtl/pulse_period_monitor_if.sv
// -----------------------------------------------------------------------------
// pulse_period_monitor_if
// Measurement result channel (valid/ready) of the pulse period monitor.
//   meas_valid   : result available (monitor -> consumer)
//   meas_ready   : consumer accepts the result (consumer -> monitor)
//   meas_period  : measured period in clock cycles
//   meas_ok      : period within tolerance
//   meas_timeout : result produced by timeout rather than by an edge
// Modports: master = monitor side, slave = consumer side.
// -----------------------------------------------------------------------------
interface pulse_period_monitor_if #(
    parameter int CNT_W = 8
);
    logic             meas_valid;
    logic             meas_ready;
    logic [CNT_W-1:0] meas_period;
    logic             meas_ok;
    logic             meas_timeout;

    modport master (
        output meas_valid,
        output meas_period,
        output meas_ok,
        output meas_timeout,
        input  meas_ready
    );

    modport slave (
        input  meas_valid,
        input  meas_period,
        input  meas_ok,
        input  meas_timeout,
        output meas_ready
    );
endinterface

// File: rtl/pulse_edge_detect.sv
// -----------------------------------------------------------------------------
// pulse_edge_detect
// Rising-edge detector for a pulse stream synchronous to clk.
//   clk        : clock
//   reset      : synchronous, active-low reset
//   pulse_in   : pulse stream
//   pulse_edge : high in the cycle pulse_in rises (pulse_in & ~pulse_q)
// A level held high produces a single edge.
// -----------------------------------------------------------------------------
module pulse_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic pulse_in,
    output logic pulse_edge
);

    logic pulse_q;

    // NOTE: reset is sampled inside the clocked block, so it only acts on a
    // clock edge; it is deliberately absent from the sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pulse_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block ordering.
            pulse_q <= pulse_in;
        end
    end

    assign pulse_edge = pulse_in & ~pulse_q;

endmodule

// File: rtl/pulse_period_monitor.sv
// -----------------------------------------------------------------------------
// pulse_period_monitor
// Measures the cycle count between rising edges of pulse_in, checks it
// against EXP_PERIOD +/- TOL, reports each result over a valid/ready channel
// and raises lock after LOCK_CNT consecutive in-tolerance results.
//
// Parameters:
//   EXP_PERIOD : expected cycles between rising edges
//   TOL        : allowed deviation in cycles
//   CNT_W      : measurement width (2**CNT_W > EXP_PERIOD+TOL+1)
//   LOCK_CNT   : consecutive ok results required for lock
// Ports:
//   clk, reset : clock, synchronous active-low reset
//   enable     : monitor enable
//   pulse_in   : pulse stream to be measured
//   mon        : result channel (pulse_period_monitor_if.master)
//   lock       : LOCK_CNT or more consecutive ok results
//   overrun    : sticky, a result was dropped because the channel was busy
//   err_cnt    : saturating count of cycles with a bad/timeout/dropped result
// Configuration:
//   PULSE_MON_ERRCNT_EN : when defined err_cnt counts; otherwise it is tied 0.
// -----------------------------------------------------------------------------
module pulse_period_monitor
    import pulse_mon_pkg::*;
#(
    parameter int EXP_PERIOD = 4,
    parameter int TOL        = 0,
    parameter int CNT_W      = 8,
    parameter int LOCK_CNT   = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   pulse_in,
    pulse_period_monitor_if.master mon,
    output logic                   lock,
    output logic                   overrun,
    output logic [ERR_W-1:0]       err_cnt
);

    localparam int RUN_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] TMO_CNT  = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(LOCK_CNT);

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RUN_W-1:0] run_q;
    logic             pulse_edge;

    logic             emit;
    logic             emit_timeout;
    logic             emit_ok;
    logic [CNT_W-1:0] emit_period;
    logic             load;

    function automatic logic in_tol(input logic [CNT_W-1:0] p);
        int d;
        d = int'(p) - EXP_PERIOD;
        if (d < 0) d = -d;
        return d <= TOL;
    endfunction

    pulse_edge_detect u_edge (
        .clk        (clk),
        .reset      (reset),
        .pulse_in   (pulse_in),
        .pulse_edge (pulse_edge)
    );

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- FSM next state / measurement ----------------
    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        cnt_d        = cnt_q;
        emit         = 1'b0;
        emit_timeout = 1'b0;
        emit_period  = cnt_q + CNT_W'(1);

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    state_d = ARM;
                end
                ARM: begin
                    // The first edge only starts the measurement window.
                    if (pulse_edge) begin
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // Edge takes priority over a coincident timeout.
                    if (pulse_edge) begin
                        emit  = 1'b1;
                        cnt_d = '0;
                    end else if (cnt_q == TMO_CNT) begin
                        emit         = 1'b1;
                        emit_timeout = 1'b1;
                        cnt_d        = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign emit_ok = emit && !emit_timeout && in_tol(emit_period);

    // A result loads when the output register is empty or being drained.
    assign load = emit && (!mon.meas_valid || mon.meas_ready);

    // ---------------- Output register, overrun, lock ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            mon.meas_valid   <= 1'b0;
            mon.meas_period  <= '0;
            mon.meas_ok      <= 1'b0;
            mon.meas_timeout <= 1'b0;
            overrun          <= 1'b0;
            run_q            <= '0;
            lock             <= 1'b0;
        end else begin
            if (load) begin
                mon.meas_valid   <= 1'b1;
                mon.meas_period  <= emit_period;
                mon.meas_ok      <= emit_ok;
                mon.meas_timeout <= emit_timeout;
            end else if (mon.meas_valid && mon.meas_ready) begin
                mon.meas_valid <= 1'b0;
            end

            if (emit && !load) begin
                overrun <= 1'b1;
            end

            // Dropped results still count towards lock. A bad result or a
            // disable clears lock at once; lock rises one cycle after the
            // run counter reaches LOCK_CNT.
            if (!enable || (emit && !emit_ok)) begin
                run_q <= '0;
                lock  <= 1'b0;
            end else begin
                if (emit && (run_q != RUN_FULL)) begin
                    run_q <= run_q + RUN_W'(1);
                end
                lock <= (run_q == RUN_FULL);
            end
        end
    end

    // ---------------- Error counter ----------------
`ifdef PULSE_MON_ERRCNT_EN
    logic err_evt;

    // One increment per cycle, even when a result is both bad and dropped.
    assign err_evt = emit && (!emit_ok || !load);

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_cnt <= '0;
        end else if (err_evt) begin
            err_cnt <= err_inc(err_cnt);
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule
